pwm_ramp_ctrl: RTL
==================

# pwm_ramp_ctrl

Controller that sequences one `not_pwm` instance in the amplifier output path. It generates the `step` strobe from a programmable prescaler, tracks the PWM period in lockstep with the PWM counter, and accepts target-duty commands over a valid/ready handshake. It ramps the applied duty toward the target only at period boundaries, which gives glitch-free, click-free level changes. A mute input forces the output to zero immediately.

## Interface
Parameters:
- `N`, 8: PWM counter/duty width; must match the driven PWM.
- `PRESCALE_W`, 16: prescaler width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `enable`  in  1: run request; low freezes sequencing and disables output.
- `prescale`  in  PRESCALE_W: one step every `prescale+1` enabled cycles.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_duty`  in  N: target duty.
- `cmd_rate`  in  4: ramp increment per period, applied as `cmd_rate+1` (1..16).
- `mute`  in  1: level-sensitive hard mute.
- `pwm_ena`  out  1: drives PWM `ena`.
- `pwm_step`  out  1: drives PWM `step`.
- `pwm_duty`  out  N: drives PWM `duty`.
- `period_done`  out  1: one-cycle pulse at each PWM period wrap.
- `busy`  out  1: high while ramping.

## Operation
- States: OFF, RAMP, HOLD. Reset enters OFF.
- In any state, `enable` low forces the next state to OFF.
- OFF with `enable` high: go to RAMP if `pwm_duty != target`, else go to HOLD.
- RAMP to HOLD when `pwm_duty` reaches `target`.
- HOLD to RAMP on an accepted command whose duty differs from `pwm_duty`.
- Prescaler `pre_cnt` counts only while `enable` is high:
  - When `pre_cnt == prescale`: `pre_cnt <= 0` and `pwm_step <= 1`.
  - Otherwise: `pre_cnt <= pre_cnt+1` and `pwm_step <= 0`.
  - `prescale = 0` gives a step every cycle.
  - A `prescale` value lowered below `pre_cnt` takes effect at the next match after wrap; the counter is `PRESCALE_W` bits and wraps.
- Period tracker `step_cnt` (N bits) increments on each `pwm_step`, exactly mirroring the PWM counter.
  - Boundary = a cycle with `pwm_step == 1` and `step_cnt == 2^N-1`.
  - At a boundary: `step_cnt <= 0` and `period_done <= 1`.
- Handshake: `cmd_ready = ~mute` (combinational). An accepted command latches `target <= cmd_duty` and `rate <= cmd_rate`. Commands are accepted in every state, including OFF.
- Ramp rule, applied only at a boundary while in RAMP:
  - `pwm_duty` moves toward `target` by `rate+1`, saturating exactly at `target`.
  - No overshoot and no wrap; compute at N+1 bits.
- Mute:
  - While high: `target <= 0` and `pwm_duty <= 0` every cycle, regardless of boundary; state is forced to HOLD if `enable`, else OFF.
  - After release, duty stays 0 until a new command.
- `pwm_ena <= (next state != OFF)`.
- `busy = (state == RAMP)`.
- Disable retains `pwm_duty`, `target`, `pre_cnt` and `step_cnt`, so the controller stays in sync with the frozen PWM counter.

## Timing
- Reset values: `pwm_ena=0`, `pwm_step=0`, `pwm_duty=0`, `period_done=0`, `busy=0`, `target=0`, `rate=0`, `pre_cnt=0`, `step_cnt=0`. `cmd_ready` follows `~mute` during reset.
- All outputs except `cmd_ready` are registered.
- First `pwm_step` is `prescale+1` cycles after `enable` rises from reset state.
- At a boundary, the `pwm_duty` update, `step_cnt` clear and `period_done` all register on the same edge. The PWM therefore sees the new duty when its counter is 0.
- Boundary update uses the target/rate held before that edge. A command accepted on a boundary cycle takes effect at the next boundary.
- Priority, highest first: `rst`, then `mute`, then `enable` low, then boundary update, then command latch.
- Enable falling: no step is issued that cycle and `pwm_ena` is 0 one cycle later.
- Reset asserted mid-ramp: all state clears asynchronously; no step and no output until after release.

## Test plan
- Reset, `enable=1`, `prescale=3`: `pwm_step` high on cycles 4, 8, 12, …; `period_done` once per 1024 cycles (N=8); `pwm_duty=0`.
- Command duty=40, rate=7, `prescale=0`: `busy=1`; `pwm_duty` 8, 16, 24, 32, 40 at successive 256-cycle boundaries; then HOLD with `busy=0`.
- From duty 40, command duty=3, rate=15: `pwm_duty` goes 24, 8, 3 (saturates, no underflow); command duty=255, rate=15 reaches 255 without wrap.
- Mute mid-ramp: `pwm_duty=0` one edge after `mute`; `cmd_ready=0`; `cmd_valid` ignored; duty stays 0 after release until a new command.
- Disable mid-ramp for 50 cycles, then re-enable: `pwm_ena` low for the window, `pre_cnt`/`step_cnt` resume unchanged, ramp continues from the retained duty.
- Command accepted on the exact boundary cycle: that boundary applies the old target; the new target applies at the next boundary. Also assert `rst` mid-ramp: all outputs 0 asynchronously.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencer for one PWM instance in the amplifier output path.
//
// Generates the PWM step strobe from a programmable prescaler, tracks the PWM period in
// lockstep with the PWM counter, accepts target-duty commands over valid/ready, and ramps
// the applied duty toward the target only at period boundaries. Mute zeroes the output at once.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   enable       run request; low freezes sequencing and disables the PWM
//   prescale     one step every prescale+1 enabled cycles
//   cmd_valid    command offered
//   cmd_ready    command accepted when cmd_valid & cmd_ready (combinational, = ~mute)
//   cmd_duty     target duty
//   cmd_rate     ramp increment per period minus one (1..16)
//   mute         level-sensitive hard mute
//   pwm_ena      PWM enable (registered)
//   pwm_step     PWM step strobe (registered)
//   pwm_duty     applied PWM duty (registered)
//   period_done  one-cycle pulse on the edge the PWM counter wraps to 0
//   busy         high while ramping
`timescale 1ns/1ps

module pwm_ramp_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [N-1:0]          cmd_duty,
    input  logic [3:0]            cmd_rate,
    input  logic                  mute,
    output logic                  pwm_ena,
    output logic                  pwm_step,
    output logic [N-1:0]          pwm_duty,
    output logic                  period_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StOff,
        StRamp,
        StHold
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  step_q, step_d;
    logic [N-1:0]          step_cnt_q, step_cnt_d;
    logic                  done_q, done_d;
    logic [N-1:0]          duty_q, duty_d;
    logic [N-1:0]          target_q, target_d;
    logic [3:0]            rate_q, rate_d;
    logic                  ena_q, ena_d;

    logic                  cmd_accept;
    logic                  boundary;

    logic [N:0]            duty_ext, tgt_ext, inc, up_sum, dn_diff;
    logic [N-1:0]          ramp_duty;

    assign cmd_ready  = ~mute;
    assign cmd_accept = cmd_valid & cmd_ready;

    // The cycle in which the PWM counter sits at its last value and is about to step to 0.
    assign boundary   = step_q & (step_cnt_q == '1);

    // One ramp step toward the target, computed one bit wider so it neither wraps nor
    // overshoots; it lands exactly on the target when the remaining distance is <= rate+1.
    always_comb begin
        duty_ext  = {1'b0, duty_q};
        tgt_ext   = {1'b0, target_q};
        inc       = {{(N-3){1'b0}}, rate_q} + {{N{1'b0}}, 1'b1};
        up_sum    = duty_ext + inc;
        dn_diff   = duty_ext - tgt_ext;
        ramp_duty = duty_q;
        if (duty_q < target_q) begin
            ramp_duty = (up_sum >= tgt_ext) ? target_q : up_sum[N-1:0];
        end else if (duty_q > target_q) begin
            ramp_duty = (dn_diff <= inc) ? target_q : (duty_q - inc[N-1:0]);
        end
    end

    // Datapath next-state: prescaler, period tracker, command latch, ramp and mute.
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        step_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        done_d     = 1'b0;
        duty_d     = duty_q;
        target_d   = target_q;
        rate_d     = rate_q;

        if (enable) begin
            if (pre_cnt_q == prescale) begin
                pre_cnt_d = '0;
                step_d    = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
        end

        // Counts every issued step, including one still in flight when enable drops,
        // because the PWM counter advances on that step too.
        if (step_q) begin
            step_cnt_d = step_cnt_q + N'(1);
        end
        if (boundary) begin
            step_cnt_d = '0;
            done_d     = 1'b1;
        end

        if (cmd_accept) begin
            target_d = cmd_duty;
            rate_d   = cmd_rate;
        end

        // Uses the registered target/rate, so a command landing on a boundary waits a period.
        if (boundary && (state_q == StRamp) && enable) begin
            duty_d = ramp_duty;
        end

        if (mute) begin
            target_d = '0;
            duty_d   = '0;
        end
    end

    // FSM next-state. Once enabled and unmuted, the state simply reflects whether the
    // duty about to be applied still differs from the target about to be held.
    always_comb begin
        state_d = state_q;
        if (mute) begin
            state_d = enable ? StHold : StOff;
        end else if (!enable) begin
            state_d = StOff;
        end else begin
            state_d = (duty_d != target_d) ? StRamp : StHold;
        end
        ena_d = (state_d != StOff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StOff;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
            done_q     <= 1'b0;
            duty_q     <= '0;
            target_q   <= '0;
            rate_q     <= '0;
            ena_q      <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            step_q     <= step_d;
            step_cnt_q <= step_cnt_d;
            done_q     <= done_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            rate_q     <= rate_d;
            ena_q      <= ena_d;
        end
    end

    assign pwm_ena     = ena_q;
    assign pwm_step    = step_q;
    assign pwm_duty    = duty_q;
    assign period_done = done_q;
    assign busy        = (state_q == StRamp);

endmodule
